// File: rtl/srt_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srt_pkg : shared constants and FSM encoding for the SRT post-processor
// Rev 1.0
// ----------------------------------------------------------------------------
package srt_pkg;

    localparam int C_WID = 8;
    localparam int C_SW  = $clog2(C_WID);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CORR  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } srt_state_e;

endpackage
`default_nettype wire

// File: rtl/srt_corr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srt_corr : combinational quotient select and remainder restore
// Rev 1.0
// ----------------------------------------------------------------------------
module srt_corr
    import srt_pkg::*;
#(
    parameter int WID = C_WID
) (
    input  logic [WID-1:0] i_rem,
    input  logic [WID-1:0] i_q,
    input  logic [WID-1:0] i_qm,
    input  logic [WID-1:0] i_dvsr,
    input  logic           i_dz,
    output logic [WID-1:0] o_quo,
    output logic [WID-1:0] o_rem
);

    logic w_neg;

    assign w_neg = i_rem[WID-1];

    // A negative final remainder means the last digit overshot: take Q-1
    // and add the divisor back to land in [0, dvsr).
    always_comb begin
        o_quo = i_q;
        o_rem = i_rem;
        if (i_dz) begin
            o_quo = '1;
        end else if (w_neg) begin
            o_quo = i_qm;
            o_rem = i_rem + i_dvsr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/srt_post.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srt_post : SRT divider post-processing (correction + remainder denormalise)
// Rev 1.0
// ----------------------------------------------------------------------------
module srt_post
    import srt_pkg::*;
#(
    parameter int WID = C_WID,
    parameter int SW  = $clog2(WID)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WID-1:0] rem_i,
    input  logic [WID-1:0] q_i,
    input  logic [WID-1:0] qm_i,
    input  logic [WID-1:0] dvsr_i,
    input  logic [SW-1:0]  shift_i,
    input  logic           dz_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WID-1:0] quo_o,
    output logic [WID-1:0] rem_o,
    output logic           dz_o
);

    srt_state_e     r_state;
    srt_state_e     w_state_next;

    logic [WID-1:0] r_rem_in;
    logic [WID-1:0] r_q;
    logic [WID-1:0] r_qm;
    logic [WID-1:0] r_dvsr;
    logic [SW-1:0]  r_shift;
    logic           r_dz;

    logic [WID-1:0] r_quo;
    logic [WID-1:0] r_rem;
    logic           r_dz_o;
    logic [SW-1:0]  r_cnt;

    logic [WID-1:0] w_quo;
    logic [WID-1:0] w_rem;
    logic           w_skip_shift;

    srt_corr #(
        .WID (WID)
    ) u_corr (
        .i_rem  (r_rem_in),
        .i_q    (r_q),
        .i_qm   (r_qm),
        .i_dvsr (r_dvsr),
        .i_dz   (r_dz),
        .o_quo  (w_quo),
        .o_rem  (w_rem)
    );

    assign w_skip_shift = r_dz || (r_shift == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = CORR;
            CORR:    w_state_next = w_skip_shift ? DONE : SHIFT;
            SHIFT:   if (r_cnt == SW'(1)) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rem_in <= '0;
            r_q      <= '0;
            r_qm     <= '0;
            r_dvsr   <= '0;
            r_shift  <= '0;
            r_dz     <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dz_o   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rem_in <= rem_i;
                        r_q      <= q_i;
                        r_qm     <= qm_i;
                        r_dvsr   <= dvsr_i;
                        r_shift  <= shift_i;
                        r_dz     <= dz_i;
                    end
                end
                CORR: begin
                    r_quo  <= w_quo;
                    r_rem  <= w_rem;
                    r_dz_o <= r_dz;
                    if (!w_skip_shift) begin
                        r_cnt <= r_shift;
                    end
                end
                SHIFT: begin
                    // Logical shift: the remainder is non-negative after restore.
                    r_rem <= r_rem >> 1;
                    r_cnt <= r_cnt - SW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quo_o     = r_quo;
    assign rem_o     = r_rem;
    assign dz_o      = r_dz_o;

endmodule
`default_nettype wire

// File: tb/tb_srt_post.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_srt_post : scoreboard bench for srt_post with directed vectors
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_srt_post;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rem_i;
    logic [7:0] q_i;
    logic [7:0] qm_i;
    logic [7:0] dvsr_i;
    logic [2:0] shift_i;
    logic       dz_i;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quo_o;
    logic [7:0] rem_o;
    logic       dz_o;

    typedef struct {
        logic [7:0] quo;
        logic [7:0] rem;
        logic       dz;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   seen   = 0;

    srt_post #(
        .WID (8),
        .SW  (3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rem_i     (rem_i),
        .q_i       (q_i),
        .qm_i      (qm_i),
        .dvsr_i    (dvsr_i),
        .shift_i   (shift_i),
        .dz_i      (dz_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo_o     (quo_o),
        .rem_o     (rem_o),
        .dz_o      (dz_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag_timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at t=%0t", nm, $time);
    endtask

    // Called and returns at posedge+1.
    task automatic send(input logic [7:0] r, input logic [7:0] q, input logic [7:0] qm,
                        input logic [7:0] dv, input logic [2:0] sh, input logic dz,
                        input logic [7:0] equo, input logic [7:0] erem, input logic edz);
        exp_t e;
        int   waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            flag_timeout("send_wait_ready");
            return;
        end
        rem_i = r; q_i = q; qm_i = qm; dvsr_i = dv; shift_i = sh; dz_i = dz;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.quo = equo;
        e.rem = erem;
        e.dz  = edz;
        e.exp_cyc = cyc + 1 + (dz ? 0 : int'(sh));
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int waited = 0;
        while ((sb.size() != 0 || !in_ready) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (sb.size() != 0 || !in_ready) flag_timeout("wait_done");
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: quo %0h rem %0h with empty scoreboard", quo_o, rem_o);
            end else begin
                if (!seen) begin
                    chk("latency_cycle", cyc, sb[0].exp_cyc);
                    seen = 1'b1;
                end
                chk("quo_o", {24'd0, quo_o}, {24'd0, sb[0].quo});
                chk("rem_o", {24'd0, rem_o}, {24'd0, sb[0].rem});
                chk("dz_o", {31'd0, dz_o}, {31'd0, sb[0].dz});
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rem_i = '0; q_i = '0; qm_i = '0; dvsr_i = '0; shift_i = '0; dz_i = 1'b0;
        #2;
        chk("rst_quo", {24'd0, quo_o}, 32'h0);
        chk("rst_rem", {24'd0, rem_o}, 32'h0);
        chk("rst_dz", {31'd0, dz_o}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        // rem, q, qm, dvsr, shift, dz  ->  quo, rem, dz
        send(8'h10, 8'h05, 8'h04, 8'h60, 3'd0, 1'b0, 8'h05, 8'h10, 1'b0);
        send(8'hF0, 8'h06, 8'h05, 8'h60, 3'd0, 1'b0, 8'h05, 8'h50, 1'b0);
        send(8'h40, 8'h0A, 8'h09, 8'h30, 3'd3, 1'b0, 8'h0A, 8'h08, 1'b0);
        send(8'h33, 8'h12, 8'h11, 8'h00, 3'd2, 1'b1, 8'hFF, 8'h33, 1'b1);
        send(8'hE0, 8'h3C, 8'h3B, 8'hA0, 3'd7, 1'b0, 8'h3B, 8'h01, 1'b0);
        send(8'hA4, 8'h22, 8'h21, 8'h7C, 3'd2, 1'b0, 8'h21, 8'h08, 1'b0);
        wait_done();

        // Back-pressure in DONE with a competing input held valid.
        out_ready = 1'b0;
        send(8'h25, 8'h07, 8'h06, 8'h40, 3'd1, 1'b0, 8'h07, 8'h12, 1'b0);
        rem_i = 8'hFF; q_i = 8'hAA; qm_i = 8'h55; dvsr_i = 8'h11; shift_i = 3'd0; dz_i = 1'b1;
        in_valid = 1'b1;
        begin
            int waited = 0;
            while (!out_valid && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!out_valid) flag_timeout("hold_wait_valid");
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready", {31'd0, in_ready}, 32'h0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'h1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'h1);
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'h0);
        chk("post_hs_sb_empty", sb.size(), 32'h0);

        // Abort a transaction in SHIFT with an asynchronous reset.
        send(8'h60, 8'h11, 8'h10, 8'h70, 3'd5, 1'b0, 8'h11, 8'h03, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_quo", {24'd0, quo_o}, 32'h11);
        chk("pre_rst_rem", {24'd0, rem_o}, 32'h30);
        #1 rstn = 1'b0;
        #1;
        chk("abort_quo", {24'd0, quo_o}, 32'h0);
        chk("abort_rem", {24'd0, rem_o}, 32'h0);
        chk("abort_dz", {31'd0, dz_o}, 32'h0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'h0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'h1);
        sb.delete();
        seen = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk); #1;
        chk("release_out_valid", {31'd0, out_valid}, 32'h0);

        send(8'h2A, 8'h03, 8'h02, 8'h40, 3'd1, 1'b0, 8'h03, 8'h15, 1'b0);
        wait_done();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
